dac_spi_tx: RTL and testbench
=============================

# dac_spi_tx

Serial transmitter that takes the 24-bit DAC command word assembled by the synth signal path and shifts it to the external 12-bit SPI DAC. The word format is {cmd[3:0], addr[3:0], data[11:0], pad[3:0]}, e.g. 24'h3F_xxx0 for "write and update all channels". The block sits between the sample/word builder and the board pins. It drives chip-select, serial clock and data, and exposes a valid/ready handshake upstream so that one word is sent per accepted request.

## Interface
- CLK_DIV, 2, system clocks per SCK half-period; legal range 1..255.
- WORD_W, 24, bits per frame; the block is verified only at 24.
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- word  input  WORD_W  frame to send, MSB first; sampled only on accept.
- valid  input  1  upstream request.
- ready  output  1  high in IDLE only; accept = valid & ready at a clk edge.
- done  output  1  one-clock pulse in the cycle spi_cs_n returns high after a complete frame.
- spi_cs_n  output  1  DAC chip select, active low.
- spi_sck  output  1  serial clock, CPOL=0; the DAC samples on the rising edge.
- spi_mosi  output  1  serial data; changes only on SCK falling edges or at frame start.

## Operation
- All outputs are registered.
- Reset values: ready=1, done=0, spi_cs_n=1, spi_sck=0, spi_mosi=0, state IDLE, all counters 0.
- Reset is asynchronous at any time, including mid-frame. Outputs take their reset values immediately, so the frame is aborted with CS high and no done pulse.
- States: IDLE, SHIFT, HOLD, GAP.
- IDLE:
  - cs_n=1, sck=0, ready=1.
  - On accept: latch word into the shift register, cs_n<=0, mosi<=word[MSB], ready<=0, bit_cnt<=0, div_cnt<=0, go to SHIFT.
- SHIFT:
  - div_cnt counts 0..CLK_DIV-1. At terminal count it wraps to 0 and sck toggles.
  - sck 0->1: no data change.
  - sck 1->0 with bit_cnt<WORD_W-1: shift left, mosi<=next bit, bit_cnt++.
  - sck 1->0 with bit_cnt==WORD_W-1: go to HOLD, keeping mosi unchanged and sck low.
- HOLD: cs_n stays low for CLK_DIV clocks. Then cs_n<=1, done<=1 for one clock, mosi<=0, go to GAP.
- GAP: cs_n high for CLK_DIV clocks (minimum CS-high time). Then ready<=1, go to IDLE.
- While ready=0, valid and word are ignored; the latched frame cannot be altered mid-transfer.
- valid held high continuously produces back-to-back frames separated by the GAP time.

## Timing
- Let E0 be the accept edge. Offsets below are clk edges after E0.
- E0: cs_n falls and mosi = bit 23. Setup to the first SCK rise is CLK_DIV clocks.
- SCK rise k (k=0..23) occurs at E0 + (2k+1)·CLK_DIV.
- SCK fall k occurs at E0 + (2k+2)·CLK_DIV. Bit 23-k is valid from fall k-1 (or E0 for k=0) until fall k.
- Last SCK fall: E0 + 48·CLK_DIV.
- cs_n rises and done pulses at E0 + 49·CLK_DIV.
- ready returns high at E0 + 50·CLK_DIV; the earliest next accept is the following edge.
- Exactly WORD_W rising SCK edges occur per frame. sck is low whenever cs_n is high.
- CLK_DIV=1: SCK = clk/2, a frame is 49 clocks to CS rise, and the IDLE-to-IDLE period is 51 clocks including the accept cycle.

## Test plan
- Basic frame:
  - Stimulus: CLK_DIV=2, word=24'h3FABC0, single valid pulse.
  - Required: the DAC model samples 0x3FABC0 on 24 SCK rises; cs_n low for exactly 98 clocks; one done pulse at E0+98; ready high at E0+100.
- Busy rejection:
  - Stimulus: during the frame above, assert valid with word=24'h3F0010.
  - Required: it is ignored; the transmitted frame is still 0x3FABC0; ready stays 0 until E0+100.
- Back-to-back frames:
  - Stimulus: valid held high, words 24'h3F0000 then 24'h3FFFF0.
  - Required: two frames; cs_n high for at least 2 clocks between them; two done pulses 101 clocks apart; correct bits in each frame.
- Reset mid-frame:
  - Stimulus: assert rst asynchronously (between clk edges) after the 10th SCK rise.
  - Required: cs_n=1, sck=0, mosi=0 and ready=1 within the same cycle; no done pulse. A fresh frame sent afterwards is received intact.
- Fast divider:
  - Stimulus: CLK_DIV=1, word=24'h3F5550.
  - Required: SCK period 2 clocks; cs_n low for 49 clocks; 24 rises; data 0x3F5550.
- Static checks across all tests:
  - mosi never changes while sck=1.
  - sck never toggles while cs_n=1.
  - The SCK rise count per CS-low window equals 24.

Source files
------------

// File: rtl/dac_spi_tx_if.sv
// Upstream handshake and SPI pin bundle for the DAC serial transmitter.
// The transmitter uses the slave modport; the word source uses the master modport.
interface dac_spi_tx_if #(
   parameter int unsigned WORD_W = 24
);
   logic [WORD_W-1:0] word;
   logic              valid;
   logic              ready;
   logic              done;
   logic              spi_cs_n;
   logic              spi_sck;
   logic              spi_mosi;

   modport master (
      output word,
      output valid,
      input  ready,
      input  done,
      input  spi_cs_n,
      input  spi_sck,
      input  spi_mosi
   );

   modport slave (
      input  word,
      input  valid,
      output ready,
      output done,
      output spi_cs_n,
      output spi_sck,
      output spi_mosi
   );
endinterface

// File: rtl/dac_spi_tx.sv
// Serial transmitter for the 24-bit DAC command word: MSB first, CPOL=0, one frame per accept.
// Each frame has a CS setup, 24 SCK periods, a CS hold, and a minimum CS-high gap.
module dac_spi_tx #(
   parameter int unsigned CLK_DIV = 2,
   parameter int unsigned WORD_W  = 24
) (
   input  logic             clk,
   input  logic             rst,
   dac_spi_tx_if.slave      bus
);
   localparam int unsigned BIT_W = $clog2(WORD_W);
   localparam logic [7:0]       DIV_LAST = 8'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_HOLD  = 2'd2,
      ST_GAP   = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [WORD_W-1:0] shreg_q, shreg_d;
   logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]        div_cnt_q, div_cnt_d;
   logic              cs_n_q, cs_n_d;
   logic              sck_q, sck_d;
   logic              mosi_q, mosi_d;
   logic              ready_q, ready_d;
   logic              done_q, done_d;
   logic              div_tc_s;

   assign div_tc_s = (div_cnt_q == DIV_LAST);

   // Next-state and registered-output computation for the frame sequencer.
   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      div_cnt_d = div_cnt_q;
      cs_n_d    = cs_n_q;
      sck_d     = sck_q;
      mosi_d    = mosi_q;
      ready_d   = ready_q;
      done_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            cs_n_d  = 1'b1;
            sck_d   = 1'b0;
            ready_d = 1'b1;
            if (bus.valid && ready_q) begin
               shreg_d   = bus.word;
               cs_n_d    = 1'b0;
               mosi_d    = bus.word[WORD_W-1];
               ready_d   = 1'b0;
               bit_cnt_d = '0;
               div_cnt_d = 8'd0;
               state_d   = ST_SHIFT;
            end else begin
               state_d   = ST_IDLE;
            end
         end

         ST_SHIFT: begin
            if (div_tc_s) begin
               div_cnt_d = 8'd0;
               sck_d     = ~sck_q;
               // Data only moves on the falling edge so the DAC sees it stable at the rise.
               if (sck_q) begin
                  if (bit_cnt_q == BIT_LAST) begin
                     state_d = ST_HOLD;
                  end else begin
                     shreg_d   = {shreg_q[WORD_W-2:0], 1'b0};
                     mosi_d    = shreg_q[WORD_W-2];
                     bit_cnt_d = bit_cnt_q + BIT_W'(1);
                  end
               end else begin
                  mosi_d = mosi_q;
               end
            end else begin
               div_cnt_d = div_cnt_q + 8'd1;
            end
         end

         ST_HOLD: begin
            if (div_tc_s) begin
               div_cnt_d = 8'd0;
               cs_n_d    = 1'b1;
               done_d    = 1'b1;
               mosi_d    = 1'b0;
               state_d   = ST_GAP;
            end else begin
               div_cnt_d = div_cnt_q + 8'd1;
            end
         end

         ST_GAP: begin
            if (div_tc_s) begin
               div_cnt_d = 8'd0;
               ready_d   = 1'b1;
               state_d   = ST_IDLE;
            end else begin
               div_cnt_d = div_cnt_q + 8'd1;
            end
         end

         default: begin
            state_d   = ST_IDLE;
            cs_n_d    = 1'b1;
            sck_d     = 1'b0;
            mosi_d    = 1'b0;
            ready_d   = 1'b1;
            bit_cnt_d = '0;
            div_cnt_d = 8'd0;
         end
      endcase
   end

   // State and output registers; reset aborts any frame with CS released.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         div_cnt_q <= 8'd0;
         cs_n_q    <= 1'b1;
         sck_q     <= 1'b0;
         mosi_q    <= 1'b0;
         ready_q   <= 1'b1;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
         div_cnt_q <= div_cnt_d;
         cs_n_q    <= cs_n_d;
         sck_q     <= sck_d;
         mosi_q    <= mosi_d;
         ready_q   <= ready_d;
         done_q    <= done_d;
      end
   end

   assign bus.ready    = ready_q;
   assign bus.done     = done_q;
   assign bus.spi_cs_n = cs_n_q;
   assign bus.spi_sck  = sck_q;
   assign bus.spi_mosi = mosi_q;
endmodule

// File: tb/tb_dac_spi_tx.sv
// Self-checking bench: a DAC receiver model captures each CS-low window and compares it
// against a scoreboard of accepted words, for a CLK_DIV=2 and a CLK_DIV=1 instance.
module tb_dac_spi_tx;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_err;
   int   cyc;

   logic [23:0] q0[$];
   logic [23:0] q1[$];
   int          done_cyc0[$];

   int          rise_n[2];
   int          low_n[2];
   int          high_n[2];
   int          last_rise[2];
   int          done_n[2];
   logic [23:0] cap[2];
   logic        prev_cs[2];
   logic        prev_sck[2];
   logic        prev_mosi[2];
   logic        had_frame[2];

   dac_spi_tx_if #(.WORD_W(24)) if2 ();
   dac_spi_tx_if #(.WORD_W(24)) if1 ();

   dac_spi_tx #(.CLK_DIV(2), .WORD_W(24)) u_dut2 (.clk(clk), .rst(rst), .bus(if2.slave));
   dac_spi_tx #(.CLK_DIV(1), .WORD_W(24)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (act !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // DAC receiver model and static protocol checks, sampled on the falling clk edge.
   initial begin
      logic        cs, sck, mosi, dn;
      int          d;
      logic [23:0] exp;
      for (int k = 0; k < 2; k++) begin
         prev_cs[k] = 1'b1; prev_sck[k] = 1'b0; prev_mosi[k] = 1'b0;
         rise_n[k] = 0; low_n[k] = 0; high_n[k] = 0; last_rise[k] = 0;
         done_n[k] = 0; cap[k] = 24'h0; had_frame[k] = 1'b0;
      end
      forever begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            cs   = (k == 0) ? if2.spi_cs_n : if1.spi_cs_n;
            sck  = (k == 0) ? if2.spi_sck  : if1.spi_sck;
            mosi = (k == 0) ? if2.spi_mosi : if1.spi_mosi;
            dn   = (k == 0) ? if2.done     : if1.done;
            d    = (k == 0) ? 2 : 1;
            if (rst) begin
               prev_cs[k] = 1'b1; prev_sck[k] = 1'b0; prev_mosi[k] = 1'b0;
               rise_n[k] = 0; low_n[k] = 0; high_n[k] = 0;
               cap[k] = 24'h0; had_frame[k] = 1'b0;
            end else begin
               if (cs) check("sck_low_while_cs_high", {31'd0, sck}, 32'd0);
               if (prev_sck[k] && sck) check("mosi_stable_while_sck_high", {31'd0, mosi}, {31'd0, prev_mosi[k]});
               if (!cs) begin
                  low_n[k] = low_n[k] + 1;
                  if (sck && !prev_sck[k]) begin
                     if (rise_n[k] > 0) check("sck_period", cyc - last_rise[k], 2 * d);
                     last_rise[k] = cyc;
                     cap[k] = {cap[k][22:0], mosi};
                     rise_n[k] = rise_n[k] + 1;
                  end
               end
               if (dn) begin
                  done_n[k] = done_n[k] + 1;
                  if (k == 0) done_cyc0.push_back(cyc);
                  check("done_with_cs_rise", {30'd0, prev_cs[k], cs}, 32'd1);
               end
               if (cs && !prev_cs[k]) begin
                  if (((k == 0) ? q0.size() : q1.size()) == 0) begin
                     check("unexpected_frame", 32'd1, 32'd0);
                  end else begin
                     exp = (k == 0) ? q0.pop_front() : q1.pop_front();
                     check("frame_data", {8'd0, cap[k]}, {8'd0, exp});
                  end
                  check("sck_rises_per_frame", rise_n[k], 24);
                  check("cs_low_clocks", low_n[k], 49 * d);
                  had_frame[k] = 1'b1;
                  high_n[k] = 0; rise_n[k] = 0; low_n[k] = 0; cap[k] = 24'h0;
               end
               if (!cs && prev_cs[k] && had_frame[k]) check("cs_gap_min", {31'd0, high_n[k] >= d}, 32'd1);
               if (cs) high_n[k] = high_n[k] + 1;
               prev_cs[k] = cs; prev_sck[k] = sck; prev_mosi[k] = mosi;
            end
         end
      end
   end

   task automatic send(input int k, input logic [23:0] w);
      @(negedge clk);
      if (k == 0) begin if2.word = w; if2.valid = 1'b1; q0.push_back(w); end
      else        begin if1.word = w; if1.valid = 1'b1; q1.push_back(w); end
      @(posedge clk);
      @(negedge clk);
      if2.valid = 1'b0;
      if1.valid = 1'b0;
   endtask

   task automatic wait_frames(input int k, input int bound);
      int n;
      n = 0;
      while ((((k == 0) ? q0.size() : q1.size()) != 0) && (n < bound)) begin
         @(negedge clk);
         #1;
         n = n + 1;
      end
      check("frame_wait_timeout", {31'd0, n < bound}, 32'd1);
   endtask

   initial begin
      int n;
      int dn_before;
      logic [23:0] w;
      n_checks = 0; n_err = 0;
      rst = 1'b1;
      if2.valid = 1'b0; if2.word = 24'h0;
      if1.valid = 1'b0; if1.word = 24'h0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_ready",  {31'd0, if2.ready},    32'd1);
      check("rst_done",   {31'd0, if2.done},     32'd0);
      check("rst_cs_n",   {31'd0, if2.spi_cs_n}, 32'd1);
      check("rst_sck",    {31'd0, if2.spi_sck},  32'd0);
      check("rst_mosi",   {31'd0, if2.spi_mosi}, 32'd0);
      check("rst_ready1", {31'd0, if1.ready},    32'd1);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Basic frame with a rejected request during the transfer
      w = 24'h3FABC0;
      if2.word = w; if2.valid = 1'b1; q0.push_back(w);
      @(posedge clk);
      @(negedge clk);
      if2.valid = 1'b0;
      check("e0_cs_low",   {31'd0, if2.spi_cs_n}, 32'd0);
      check("e0_mosi_msb", {31'd0, if2.spi_mosi}, {31'd0, w[23]});
      check("e0_ready_lo", {31'd0, if2.ready},    32'd0);
      for (int i = 1; i <= 100; i++) begin
         @(negedge clk);
         if (i == 10) begin if2.word = 24'h3F0010; if2.valid = 1'b1; end
         if (i == 20) if2.valid = 1'b0;
         if (i == 97 || i == 99) check("done_outside_slot", {31'd0, if2.done}, 32'd0);
         if (i == 98) check("done_at_e0_98", {31'd0, if2.done}, 32'd1);
         if (i == 50 || i == 99) check("ready_busy", {31'd0, if2.ready}, 32'd0);
         if (i == 100) check("ready_at_e0_100", {31'd0, if2.ready}, 32'd1);
      end
      wait_frames(0, 50);

      // Back-to-back frames with valid held high
      @(negedge clk);
      if2.word = 24'h3F0000; if2.valid = 1'b1;
      q0.push_back(24'h3F0000);
      q0.push_back(24'h3FFFF0);
      @(posedge clk);
      @(negedge clk);
      if2.word = 24'h3FFFF0;
      for (int i = 1; i <= 101; i++) @(negedge clk);
      if2.valid = 1'b0;
      wait_frames(0, 400);
      n = done_cyc0.size();
      check("b2b_done_count", n, 3);
      if (n >= 2) check("b2b_done_spacing", done_cyc0[n-1] - done_cyc0[n-2], 101);

      // Asynchronous reset after the 10th SCK rise
      repeat (4) @(negedge clk);
      send(0, 24'h3F1230);
      n = 0;
      while (rise_n[0] < 10 && n < 200) begin
         @(negedge clk);
         #1;
         n = n + 1;
      end
      check("rise10_timeout", {31'd0, n < 200}, 32'd1);
      dn_before = done_n[0];
      #1 rst = 1'b1;
      #1;
      check("arst_cs_n",  {31'd0, if2.spi_cs_n}, 32'd1);
      check("arst_sck",   {31'd0, if2.spi_sck},  32'd0);
      check("arst_mosi",  {31'd0, if2.spi_mosi}, 32'd0);
      check("arst_ready", {31'd0, if2.ready},    32'd1);
      repeat (3) @(negedge clk);
      q0.delete();
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check("arst_no_done", done_n[0], dn_before);
      send(0, 24'h3F0AB0);
      wait_frames(0, 200);

      // Fast divider instance
      repeat (3) @(negedge clk);
      send(1, 24'h3F5550);
      wait_frames(1, 200);
      check("fast_done_count", done_n[1], 1);

      repeat (5) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
